// File: rtl/regfile_trace_unit.sv
// Register-file trace engine: snapshots the register file on each retire pulse
// and streams (index, value, seq) records plus a trailer over valid/ready.
module regfile_trace_unit #(
  parameter  int NREGS = 32,
  parameter  int DW    = 32,
  parameter  int SEQW  = 8,
  parameter  int CNTW  = 16,
  localparam int IDXW  = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_done,
  input  logic [NREGS*DW-1:0] regs_flat,
  input  logic                mode_delta,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [IDXW-1:0]     out_idx,
  output logic [DW-1:0]       out_data,
  output logic [SEQW-1:0]     out_seq,
  output logic                out_last,
  output logic                busy,
  output logic [CNTW-1:0]     drop_cnt
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    TRAIL
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]   shadow [NREGS];
  logic [DW-1:0]   prev   [NREGS];
  logic [AW-1:0]   idx;
  logic [IDXW-1:0] rec_cnt;
  logic [SEQW-1:0] seq;
  logic            delta;

  logic sel;
  logic last_reg;
  logic adv;
  logic start;
  logic trail_acc;

  assign busy      = (state != IDLE);
  assign start     = (state == IDLE) && instr_done;
  assign sel       = !delta || (shadow[idx] != prev[idx]);
  assign last_reg  = (idx == AW'(NREGS - 1));
  assign adv       = (state == SCAN) && (!sel || out_ready);
  assign trail_acc = (state == TRAIL) && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs depend only on registered state, never on out_ready.
  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    out_seq   = '0;
    unique case (state)
      IDLE: begin
        if (instr_done) state_nx = SCAN;
      end
      SCAN: begin
        if (sel) begin
          out_valid = 1'b1;
          out_idx   = IDXW'(idx);
          out_data  = shadow[idx];
          out_seq   = seq;
        end
        if (adv && last_reg) state_nx = TRAIL;
      end
      TRAIL: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_idx   = '1;
        out_data  = DW'(rec_cnt);
        out_seq   = seq;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        shadow[k] <= '0;
        prev[k]   <= '0;
      end
      idx      <= '0;
      rec_cnt  <= '0;
      seq      <= '0;
      delta    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (start) begin
        for (int k = 0; k < NREGS; k++)
          shadow[k] <= regs_flat[k*DW +: DW];
        delta   <= mode_delta;
        idx     <= '0;
        rec_cnt <= '0;
      end
      if (adv) begin
        if (!last_reg) idx <= idx + 1'b1;
        if (sel) rec_cnt <= rec_cnt + 1'b1;
      end
      // prev only tracks snapshots that were fully streamed.
      if (trail_acc) begin
        for (int k = 0; k < NREGS; k++)
          prev[k] <= shadow[k];
        seq <= seq + 1'b1;
      end
      if (busy && instr_done && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_trace_unit.sv
// Bench for regfile_trace_unit: random snapshots checked against a queue model.
// A second instance with SEQW=2, CNTW=2 shares all inputs for wrap/saturation.
module tb_regfile_trace_unit;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int IDXW  = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                instr_done = 1'b0;
  logic                mode_delta = 1'b0;
  logic                out_ready = 1'b0;
  logic [NREGS*DW-1:0] regs_flat = '0;

  logic            valid_a, last_a, busy_a;
  logic [IDXW-1:0] idx_a;
  logic [DW-1:0]   data_a;
  logic [7:0]      seq_a;
  logic [15:0]     drop_a;

  logic            valid_b, last_b, busy_b;
  logic [IDXW-1:0] idx_b;
  logic [DW-1:0]   data_b;
  logic [1:0]      seq_b;
  logic [1:0]      drop_b;

  regfile_trace_unit dut_a (
    .clk(clk), .rst(rst), .instr_done(instr_done),
    .regs_flat(regs_flat), .mode_delta(mode_delta),
    .out_ready(out_ready), .out_valid(valid_a), .out_idx(idx_a),
    .out_data(data_a), .out_seq(seq_a), .out_last(last_a),
    .busy(busy_a), .drop_cnt(drop_a)
  );

  regfile_trace_unit #(.SEQW(2), .CNTW(2)) dut_b (
    .clk(clk), .rst(rst), .instr_done(instr_done),
    .regs_flat(regs_flat), .mode_delta(mode_delta),
    .out_ready(out_ready), .out_valid(valid_b), .out_idx(idx_b),
    .out_data(data_b), .out_seq(seq_b), .out_last(last_b),
    .busy(busy_b), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [DW-1:0] snap [NREGS];
  logic [DW-1:0] prev [NREGS];
  int snaps = 0;
  int drops = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 0; k < NREGS; k++)
      regs_flat[k*DW +: DW] = snap[k];
  endtask

  task automatic scramble();
    for (int k = 0; k < NREGS; k++)
      regs_flat[k*DW +: DW] = $urandom;
    mode_delta = 1'($urandom_range(0, 1));
  endtask

  // One snapshot: pulse, then consume the stream against the expected list.
  task automatic stream(input bit dlt, input bit rnd_ready,
                        input int extra, input bit timing);
    int            qi[$];
    logic [DW-1:0] qd[$];
    int            nrec;
    bit            done;
    for (int k = 0; k < NREGS; k++)
      if (!dlt || snap[k] != prev[k]) begin
        qi.push_back(k);
        qd.push_back(snap[k]);
      end
    nrec = qi.size();
    pack();
    mode_delta = dlt;
    out_ready  = 1'b0;
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    chk("busy_start", busy_a, 1);
    done = 1'b0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      instr_done = (cyc <= 2 * extra) && (cyc % 2 == 1);
      if (cyc > 1) scramble();
      if (valid_a) begin
        chk("seq_a", seq_a, snaps % 256);
        chk("seq_b", seq_b, snaps % 4);
        chk("valid_b", valid_b, 1);
        if (qi.size() > 0) begin
          chk("rec_idx", idx_a, qi[0]);
          chk("rec_data", data_a, qd[0]);
          chk("rec_last", last_a, 0);
          if (out_ready) begin
            void'(qi.pop_front());
            void'(qd.pop_front());
          end
        end else begin
          chk("trl_idx", idx_a, 6'h3F);
          chk("trl_data", data_a, nrec);
          chk("trl_last", last_a, 1);
          if (out_ready) begin
            done = 1'b1;
            if (timing) chk("trl_cycle", cyc, NREGS + 1);
          end
        end
      end
      step();
    end
    instr_done = 1'b0;
    out_ready  = 1'b0;
    chk("stream_done", done, 1);
    chk("busy_end", busy_a, 0);
    for (int k = 0; k < NREGS; k++) prev[k] = snap[k];
    snaps++;
    drops += extra;
    chk("drop_a", drop_a, (drops > 65535) ? 65535 : drops);
    chk("drop_b", drop_b, (drops > 3) ? 3 : drops);
  endtask

  initial begin
    for (int k = 0; k < NREGS; k++) begin
      snap[k] = '0;
      prev[k] = '0;
    end
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", valid_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_seq", seq_a, 0);
    chk("rst_drop", drop_a, 0);
    rst = 1'b0;
    step();

    // Abandon a stream with a mid-stream asynchronous reset.
    for (int k = 0; k < NREGS; k++) snap[k] = k + 100;
    pack();
    mode_delta = 1'b0;
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    step();
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    step();
    chk("drop_pre_rst", drop_a, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_drop", drop_a, 0);
    step();
    rst = 1'b0;
    step();

    // First delta after reset compares against all-zero history.
    for (int k = 0; k < NREGS; k++)
      snap[k] = (k % 3 == 0) ? '0 : $urandom;
    stream(1'b1, 1'b0, 0, 1'b0);

    for (int k = 0; k < NREGS; k++) snap[k] = k;
    stream(1'b0, 1'b0, 0, 1'b1);

    snap[5] = 7;
    stream(1'b0, 1'b0, 0, 1'b0);
    snap[5] = 9;
    stream(1'b1, 1'b0, 0, 1'b0);
    stream(1'b1, 1'b0, 0, 1'b0);

    for (int k = 0; k < NREGS; k++) snap[k] = $urandom;
    stream(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) snap[$urandom_range(0, NREGS - 1)] = $urandom;
    stream(1'b1, 1'b1, 3, 1'b0);
    stream(1'b0, 1'b1, 2, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++)
        snap[$urandom_range(0, NREGS - 1)] = $urandom;
      stream(1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
